hazard_ctrl: RTL



---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/hazard_detect.sv | 30 +++
 rtl/hazard_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline types and constants: hazard controller state
//                encoding and register-field definitions.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

   // Width of an architectural register index field
   localparam int REG_W = 5;

   // Register $zero: writes to it are discarded, so it never creates a hazard
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   // Hazard controller state encoding
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hz_state_e;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use comparator. Flags an ID-stage
//                instruction that reads the destination of a load in EX.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_dest,
   output logic             load_use
);

   logic w_rs_match;
   logic w_rt_match;

   // rt is only a real source when the ID instruction actually reads it
   assign w_rs_match = (ex_dest == id_rs);
   assign w_rt_match = id_uses_rt && (ex_dest == id_rt);

   // A load into $zero produces nothing to wait for
   assign load_use = ex_memread && (ex_dest != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard/stall controller. Drives PC, IF/ID, ID/EX and
//                EX/MEM enables and flushes; inserts load-use bubbles, flushes
//                on redirects, freezes on slow memory, halts on a memory
//                timeout and counts stalled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 256,   // must be >= 2
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_dest,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             perf_clear,
   output logic             pc_enable,
   output logic             if_id_enable,
   output logic             if_id_flush,
   output logic             id_ex_enable,
   output logic             id_ex_flush,
   output logic             ex_mem_enable,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   // Wait counter must be able to hold MEM_TIMEOUT itself
   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] c_WAIT_ONE  = WAIT_W'(1);

   hz_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

   logic w_load_use;
   logic w_mem_busy;
   logic w_pc_en, w_ifid_en, w_ifid_fl, w_idex_en, w_idex_fl, w_exmem_en;

   hazard_detect u_detect (
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .ex_memread (ex_memread),
      .ex_dest    (ex_dest),
      .load_use   (w_load_use)
   );

   assign w_mem_busy = mem_req && !mem_ready;

   // Same-cycle pipeline control and FSM next-state selection
   always_comb begin
      w_pc_en       = 1'b1;
      w_ifid_en     = 1'b1;
      w_ifid_fl     = 1'b0;
      w_idex_en     = 1'b1;
      w_idex_fl     = 1'b0;
      w_exmem_en    = 1'b1;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;

      case (state_q)
         RUN: begin
            if (w_mem_busy) begin
               // Freeze everything; nothing is flushed so no work is lost
               w_pc_en    = 1'b0;
               w_ifid_en  = 1'b0;
               w_idex_en  = 1'b0;
               w_exmem_en = 1'b0;
               state_d    = MEM_WAIT;
               wait_cnt_d = c_WAIT_ONE;
            end else if (ex_redirect) begin
               // Wrong-path instructions in IF/ID and ID/EX are squashed;
               // this also cancels any load-use stall on the same path
               w_ifid_fl = 1'b1;
               w_idex_fl = 1'b1;
            end else if (w_load_use) begin
               // Hold PC and IF/ID, inject one bubble into ID/EX
               w_pc_en   = 1'b0;
               w_ifid_en = 1'b0;
               w_idex_fl = 1'b1;
            end
         end

         MEM_WAIT: begin
            if (!mem_ready) begin
               // Still frozen; redirect and load-use wait for release
               w_pc_en    = 1'b0;
               w_ifid_en  = 1'b0;
               w_idex_en  = 1'b0;
               w_exmem_en = 1'b0;
               wait_cnt_d = wait_cnt_q + c_WAIT_ONE;
               if (wait_cnt_q == c_WAIT_LAST) begin
                  state_d       = HALT;
                  mem_timeout_d = 1'b1;
               end
            end else begin
               // Access completes: resume and re-evaluate held hazards
               state_d    = RUN;
               wait_cnt_d = '0;
               if (ex_redirect) begin
                  w_ifid_fl = 1'b1;
                  w_idex_fl = 1'b1;
               end else if (w_load_use) begin
                  w_pc_en   = 1'b0;
                  w_ifid_en = 1'b0;
                  w_idex_fl = 1'b1;
               end
            end
         end

         HALT: begin
            // Terminal until reset
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_idex_en     = 1'b0;
            w_exmem_en    = 1'b0;
            mem_timeout_d = 1'b1;
         end

         default: begin
            // Unreachable encoding: freeze and recover into RUN
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase

      // While reset is held the pipeline registers are neither loaded nor cleared
      if (!reset) begin
         w_pc_en    = 1'b0;
         w_ifid_en  = 1'b0;
         w_ifid_fl  = 1'b0;
         w_idex_en  = 1'b0;
         w_idex_fl  = 1'b0;
         w_exmem_en = 1'b0;
      end
   end

   // Stall counter: clear has priority, increment saturates at all-ones
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (perf_clear)
         stall_cycles_d = '0;
      else if (!w_pc_en && (stall_cycles_q != {CNT_W{1'b1}}))
         stall_cycles_d = stall_cycles_q + 1'b1;
   end

   // FSM state, wait counter, watchdog flag and stall counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= RUN;
         wait_cnt_q     <= '0;
         mem_timeout_q  <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         mem_timeout_q  <= mem_timeout_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign pc_enable     = w_pc_en;
   assign if_id_enable  = w_ifid_en;
   assign if_id_flush   = w_ifid_fl;
   assign id_ex_enable  = w_idex_en;
   assign id_ex_flush   = w_idex_fl;
   assign ex_mem_enable = w_exmem_en;
   assign mem_timeout   = mem_timeout_q;
   assign stall_cycles  = stall_cycles_q;

endmodule : hazard_ctrl
`default_nettype wire
